uart_tx_arbiter: RTL and testbench

Two-requester arbiter that shares the single UART transmitter between byte-stream sources (core MMIO TX path on port 0, debug/boot responder on port 1). It locks the grant for a whole packet, delimited by a `last` flag, so messages from different sources never interleave on the serial line. It sits between the requesters and the UART transmitter inside the `uart` subsystem. A one-byte registered output stage presents bytes to the transmitter with a valid/ready handshake.

---
 rtl/uart_tx_arbiter_if.sv | 42 ++++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter-side signals of the UART TX arbiter, bundled as one port.
// slave = arbiter view, master = requesters plus UART transmitter view.
interface uart_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid_i;
    logic [DATA_W-1:0] req0_data_i;
    logic              req0_last_i;
    logic              req0_ready_o;

    logic              req1_valid_i;
    logic [DATA_W-1:0] req1_data_i;
    logic              req1_last_i;
    logic              req1_ready_o;

    logic              tx_valid_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_ready_i;

    logic [1:0]        grant_o;
    logic              timeout_o;

    modport slave (
        input  req0_valid_i, req0_data_i, req0_last_i,
        output req0_ready_o,
        input  req1_valid_i, req1_data_i, req1_last_i,
        output req1_ready_o,
        output tx_valid_o, tx_data_o,
        input  tx_ready_i,
        output grant_o, timeout_o
    );

    modport master (
        output req0_valid_i, req0_data_i, req0_last_i,
        input  req0_ready_o,
        output req1_valid_i, req1_data_i, req1_last_i,
        input  req1_ready_o,
        input  tx_valid_o, tx_data_o,
        output tx_ready_i,
        input  grant_o, timeout_o
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX between two byte streams; one-byte output register.
// Latency: valid in IDLE at N -> grant/ready at N+1 -> tx_valid at N+2; 1 byte/cycle while tx_ready stays high.
// Backpressure: owner ready = !tx_valid | tx_ready. Optional idle-owner release via UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              resetn,
    uart_tx_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;   // 0: req0, 1: req1
    logic              rr_q, rr_d;         // requester preferred on a tie
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;

    logic              own_valid;
    logic              own_last;
    logic [DATA_W-1:0] own_data;
    logic              hold_free;
    logic              own_hs;
    logic              idle_expire;

    always_comb begin
        own_valid = bus.req0_valid_i;
        own_last  = bus.req0_last_i;
        own_data  = bus.req0_data_i;
        if (owner_q) begin
            own_valid = bus.req1_valid_i;
            own_last  = bus.req1_last_i;
            own_data  = bus.req1_data_i;
        end
    end

    assign hold_free = !tx_valid_q || bus.tx_ready_i;
    assign own_hs    = (state_q == OWN) && own_valid && hold_free;

    assign bus.req0_ready_o = (state_q == OWN) && !owner_q && hold_free;
    assign bus.req1_ready_o = (state_q == OWN) &&  owner_q && hold_free;
    assign bus.grant_o      = (state_q == OWN) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.tx_valid_o   = tx_valid_q;
    assign bus.tx_data_o    = tx_data_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             timeout_q, timeout_d;

    // Expire on the TIMEOUT_CYC-th consecutive owner-idle cycle so IDLE follows immediately.
    assign idle_expire = (state_q == OWN) && !own_valid &&
                         (idle_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        timeout_d  = idle_expire;
        if (state_q != OWN || own_valid || idle_expire) begin
            idle_cnt_d = '0;
        end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            idle_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign idle_expire   = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (bus.req0_valid_i || bus.req1_valid_i) begin
                    state_d = OWN;
                    owner_d = (bus.req0_valid_i && bus.req1_valid_i) ? rr_q : bus.req1_valid_i;
                end
            end
            OWN: begin
                if ((own_hs && own_last) || idle_expire) begin
                    state_d = IDLE;
                    rr_d    = !owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The holding register drains on its own, independent of who owns the lock.
    always_comb begin
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        if (own_hs) begin
            tx_valid_d = 1'b1;
            tx_data_d  = own_data;
        end else if (bus.tx_ready_i) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table, corner-case sequences, then randomized traffic vs a packet-level model.
// Build with UART_ARB_TIMEOUT_EN to exercise forced release (TIMEOUT_CYC = 8).
module tb_uart_tx_arbiter;

    localparam int DW = 8;

    logic clk_i  = 1'b0;
    logic resetn = 1'b0;
    always #5 clk_i = ~clk_i;

    uart_tx_arbiter_if #(.DATA_W(DW)) bus ();

    uart_tx_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(8)) dut (
        .clk_i  (clk_i),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       v0;
        logic [7:0] d0;
        logic       l0;
        logic       v1;
        logic [7:0] d1;
        logic       l1;
        logic       txr;
        logic [1:0] g;
        logic       r0;
        logic       r1;
        logic       txv;
        logic       cd;
        logic [7:0] txd;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] sd [2][256];
    logic       sl [2][256];
    int         nitems [2];
    int         pos    [2];
    int         gap    [2];
    logic [7:0] hold[$];
    logic [1:0] pred_g;
    logic [1:0] smp_g, smp_v, smp_r;
    logic       smp_txv, smp_txr, hs_last, favour;
    logic [7:0] smp_txd;
    int         cyc, nout, total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic rst, logic v0, logic [7:0] d0, logic l0,
                                logic v1, logic [7:0] d1, logic l1, logic txr,
                                logic [1:0] g, logic r0, logic r1, logic txv,
                                logic cd, logic [7:0] txd);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.d0 = d0; v.l0 = l0;
        v.v1 = v1; v.d1 = d1; v.l1 = l1; v.txr = txr;
        v.g = g; v.r0 = r0; v.r1 = r1; v.txv = txv; v.cd = cd; v.txd = txd;
        return v;
    endfunction

    task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1, input logic txr);
        bus.req0_valid_i = v0; bus.req0_data_i = d0; bus.req0_last_i = l0;
        bus.req1_valid_i = v1; bus.req1_data_i = d1; bus.req1_last_i = l1;
        bus.tx_ready_i   = txr;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        resetn = 1'b1;
        step();
    endtask

    initial begin
        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
        #1;
        chk("reset_grant",   bus.grant_o,      2'b00);
        chk("reset_txv",     bus.tx_valid_o,   1'b0);
        chk("reset_txd",     bus.tx_data_o,    8'h00);
        chk("reset_timeout", bus.timeout_o,    1'b0);
        chk("reset_rdy",     {bus.req1_ready_o, bus.req0_ready_o}, 2'b00);

        // 3-byte packet from req0, then simultaneous requests from a fresh reset
        vecs.push_back(mk(1, 1, 8'h41, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 1, 8'h00));
        vecs.push_back(mk(0, 1, 8'h41, 0, 0, 8'h00, 0, 1, 2'b01, 1, 0, 0, 1, 8'h00));
        vecs.push_back(mk(0, 1, 8'h42, 0, 0, 8'h00, 0, 1, 2'b01, 1, 0, 1, 1, 8'h41));
        vecs.push_back(mk(0, 1, 8'h43, 1, 0, 8'h00, 0, 1, 2'b01, 1, 0, 1, 1, 8'h42));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 1, 1, 8'h43));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(1, 1, 8'h10, 0, 1, 8'h20, 1, 1, 2'b00, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h10, 0, 1, 8'h20, 1, 1, 2'b01, 1, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h11, 1, 1, 8'h20, 1, 1, 2'b01, 1, 0, 1, 1, 8'h10));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h20, 1, 1, 2'b00, 0, 0, 1, 1, 8'h11));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h20, 1, 1, 2'b10, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 1, 8'h12, 1, 1, 8'h21, 1, 1, 2'b00, 0, 0, 1, 1, 8'h20));
        vecs.push_back(mk(0, 1, 8'h12, 1, 1, 8'h21, 1, 1, 2'b01, 1, 0, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h21, 1, 1, 2'b00, 0, 0, 1, 1, 8'h12));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1, 8'h21, 1, 1, 2'b10, 0, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 1, 1, 8'h21));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 2'b00, 0, 0, 0, 0, 8'h00));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            drive(vecs[i].v0, vecs[i].d0, vecs[i].l0, vecs[i].v1, vecs[i].d1, vecs[i].l1, vecs[i].txr);
            @(negedge clk_i);
            chk($sformatf("vec%0d_grant", i), bus.grant_o,      vecs[i].g);
            chk($sformatf("vec%0d_rdy0", i),  bus.req0_ready_o, vecs[i].r0);
            chk($sformatf("vec%0d_rdy1", i),  bus.req1_ready_o, vecs[i].r1);
            chk($sformatf("vec%0d_txv", i),   bus.tx_valid_o,   vecs[i].txv);
            if (vecs[i].cd) chk($sformatf("vec%0d_txd", i), bus.tx_data_o, vecs[i].txd);
            step();
        end

        // Backpressure: 0x55 held five cycles, then 0x56 follows exactly once
        do_reset();
        drive(1, 8'h55, 0, 0, 8'h00, 0, 1);
        @(negedge clk_i); step();
        @(negedge clk_i);
        chk("bp_grant", bus.grant_o, 2'b01);
        chk("bp_rdy_first", bus.req0_ready_o, 1'b1);
        step();
        drive(1, 8'h56, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("bp_hold_txv", bus.tx_valid_o,   1'b1);
            chk("bp_hold_txd", bus.tx_data_o,    8'h55);
            chk("bp_hold_rdy", bus.req0_ready_o, 1'b0);
            step();
        end
        bus.tx_ready_i = 1'b1;
        @(negedge clk_i);
        chk("bp_release_rdy", bus.req0_ready_o, 1'b1);
        chk("bp_release_txd", bus.tx_data_o,    8'h55);
        step();
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        @(negedge clk_i);
        chk("bp_next_txv",  bus.tx_valid_o, 1'b1);
        chk("bp_next_txd",  bus.tx_data_o,  8'h56);
        chk("bp_idle",      bus.grant_o,    2'b00);
        step();
        @(negedge clk_i);
        chk("bp_drained", bus.tx_valid_o, 1'b0);
        step();

        // req1 stalls mid-packet while req0 waits; lock must hold
        do_reset();
        drive(0, 8'h00, 0, 1, 8'h30, 0, 1);
        @(negedge clk_i); step();
        @(negedge clk_i);
        chk("mid_grant1", bus.grant_o,      2'b10);
        chk("mid_rdy1",   bus.req1_ready_o, 1'b1);
        step();
        drive(1, 8'h01, 1, 0, 8'h00, 0, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            chk("mid_hold_grant", bus.grant_o,      2'b10);
            chk("mid_hold_rdy0",  bus.req0_ready_o, 1'b0);
            step();
        end
        drive(1, 8'h01, 1, 1, 8'h31, 1, 1);
        @(negedge clk_i);
        chk("mid_resume_rdy1", bus.req1_ready_o, 1'b1);
        chk("mid_resume_rdy0", bus.req0_ready_o, 1'b0);
        step();
        drive(1, 8'h01, 1, 0, 8'h00, 0, 1);
        @(negedge clk_i);
        chk("mid_end_grant", bus.grant_o,   2'b00);
        chk("mid_end_txd",   bus.tx_data_o, 8'h31);
        chk("mid_end_rdy0",  bus.req0_ready_o, 1'b0);
        step();
        @(negedge clk_i);
        chk("mid_next_grant", bus.grant_o,      2'b01);
        chk("mid_next_rdy0",  bus.req0_ready_o, 1'b1);
        step();

        // Owner req0 goes quiet mid-packet while req1 waits
        do_reset();
        drive(1, 8'h60, 0, 1, 8'h70, 1, 1);
        @(negedge clk_i); step();
        @(negedge clk_i);
        chk("to_grant0", bus.grant_o, 2'b01);
        step();
        drive(0, 8'h00, 0, 1, 8'h70, 1, 1);
`ifdef UART_ARB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            chk("to_wait_grant",   bus.grant_o,   2'b01);
            chk("to_wait_timeout", bus.timeout_o, 1'b0);
            step();
        end
        @(negedge clk_i);
        chk("to_pulse",      bus.timeout_o, 1'b1);
        chk("to_pulse_idle", bus.grant_o,   2'b00);
        step();
        @(negedge clk_i);
        chk("to_pulse_once", bus.timeout_o, 1'b0);
        chk("to_next_grant", bus.grant_o,   2'b10);
        step();
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        step();
`else
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            chk("hold_grant",   bus.grant_o,      2'b01);
            chk("hold_rdy1",    bus.req1_ready_o, 1'b0);
            chk("hold_timeout", bus.timeout_o,    1'b0);
            step();
        end
        drive(1, 8'h61, 1, 1, 8'h70, 1, 1);
        step();
        drive(0, 8'h00, 0, 1, 8'h70, 1, 1);
        @(negedge clk_i);
        chk("hold_release_idle", bus.grant_o, 2'b00);
        step();
        @(negedge clk_i);
        chk("hold_next_grant", bus.grant_o, 2'b10);
        step();
        drive(0, 8'h00, 0, 0, 8'h00, 0, 1);
        step();
`endif

        // Asynchronous reset with 0x7E stuck in the holding register; pointer was favouring req1
        do_reset();
        drive(1, 8'h7D, 1, 0, 8'h00, 0, 1);
        @(negedge clk_i); step();
        step();
        drive(1, 8'h7E, 0, 0, 8'h00, 0, 1);
        step();
        bus.tx_ready_i = 1'b0;
        step();
        drive(0, 8'h00, 0, 0, 8'h00, 0, 0);
        @(negedge clk_i);
        chk("ar_pre_txv", bus.tx_valid_o, 1'b1);
        chk("ar_pre_txd", bus.tx_data_o,  8'h7E);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_txv",   bus.tx_valid_o, 1'b0);
        chk("ar_grant", bus.grant_o,    2'b00);
        chk("ar_txd",   bus.tx_data_o,  8'h00);
        drive(1, 8'h01, 1, 1, 8'h02, 1, 1);
        @(negedge clk_i);
        resetn = 1'b1;
        step();
        @(negedge clk_i);
        chk("ar_first_grant", bus.grant_o, 2'b01);
        step();

        // Randomized traffic against a packet-level reference
        do_reset();
        total = 0;
        for (int s = 0; s < 2; s++) begin
            nitems[s] = 0;
            pos[s]    = 0;
            gap[s]    = $urandom_range(0, 2);
            while (nitems[s] < 240) begin
                int len;
                len = $urandom_range(1, 4);
                for (int j = 0; j < len; j++) begin
                    sd[s][nitems[s]] = 8'($urandom);
                    sl[s][nitems[s]] = (j == len - 1);
                    nitems[s]++;
                end
            end
            total += nitems[s];
        end
        favour = 1'b0;
        pred_g = 2'b00;
        nout   = 0;
        cyc    = 0;
        while ((pos[0] < nitems[0] || pos[1] < nitems[1] || hold.size() != 0) && cyc < 20000) begin
            cyc++;
            for (int s = 0; s < 2; s++) begin
                logic       pv;
                logic [7:0] pd;
                logic       pl;
                pv = 1'b0; pd = 8'h00; pl = 1'b0;
                if (pos[s] < nitems[s] && gap[s] == 0) begin
                    pv = 1'b1; pd = sd[s][pos[s]]; pl = sl[s][pos[s]];
                end else if (gap[s] > 0) begin
                    gap[s]--;
                end
                if (s == 0) begin
                    bus.req0_valid_i = pv; bus.req0_data_i = pd; bus.req0_last_i = pl;
                end else begin
                    bus.req1_valid_i = pv; bus.req1_data_i = pd; bus.req1_last_i = pl;
                end
            end
            bus.tx_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            smp_g   = bus.grant_o;
            smp_v   = {bus.req1_valid_i, bus.req0_valid_i};
            smp_r   = {bus.req1_ready_o, bus.req0_ready_o};
            smp_txv = bus.tx_valid_o;
            smp_txr = bus.tx_ready_i;
            smp_txd = bus.tx_data_o;
            chk("rnd_grant", smp_g, pred_g);
            chk("rnd_rdy0", smp_r[0], smp_g[0] && (hold.size() == 0 || smp_txr));
            chk("rnd_rdy1", smp_r[1], smp_g[1] && (hold.size() == 0 || smp_txr));
            chk("rnd_txv", smp_txv, hold.size() != 0);
            if (smp_txv && smp_txr && hold.size() != 0) begin
                chk("rnd_txd", smp_txd, hold.pop_front());
                nout++;
            end
            hs_last = 1'b0;
            for (int s = 0; s < 2; s++) begin
                if (smp_v[s] && smp_r[s]) begin
                    hold.push_back(sd[s][pos[s]]);
                    if (sl[s][pos[s]]) begin
                        hs_last = 1'b1;
                        favour  = (s == 0);
                        gap[s]  = $urandom_range(0, 3);
                    end else begin
                        gap[s]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                    end
                    pos[s]++;
                end
            end
            if (smp_g == 2'b00)
                pred_g = (smp_v == 2'b11) ? (favour ? 2'b10 : 2'b01) : smp_v;
            else
                pred_g = hs_last ? 2'b00 : smp_g;
            step();
        end
        chk("rnd_all_accepted", (pos[0] == nitems[0]) && (pos[1] == nitems[1]), 1'b1);
        chk("rnd_bytes_out", nout, total);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
